gate_accumulator: RTL and testbench
===================================

GATE_ACCUMULATOR -- requirements
Module: gate_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result bit width (>=1).
REQ-002 SHALL have parameter NUM_OPERANDS, default 4, operands folded per result (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mode  input  3  gate select: 0 NOR, 1 OR, 2 NAND, 3 AND, 4 XNOR, 5 XOR, 6-7 reserved.
REQ-006 SHALL have port in_valid  input  1  operand beat offered.
REQ-007 SHALL have port in_ready  output  1  operand beat accepted when in_valid&&in_ready.
REQ-008 SHALL have port in_data  input  WIDTH  operand.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  result consumed when out_valid&&out_ready.
REQ-011 SHALL have port out_data  output  WIDTH  bitwise result over all NUM_OPERANDS operands.
REQ-012 SHALL have port out_illegal  output  1  latched mode was reserved/disabled; result computed as NOR.

Function
REQ-013 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-014 IDLE: in_ready=1; accepted beat loads acc<=in_data, latches mode, cnt<=1, next ACCUM.
REQ-015 ACCUM: in_ready=1; accepted beat sets acc<=acc OP in_data (OP = OR/AND/XOR base of latched mode), cnt<=cnt+1; beat making cnt==NUM_OPERANDS moves to DONE.
REQ-016 ACCUM with in_valid low SHALL hold acc, cnt and state; no timeout.
REQ-017 DONE: in_ready=0, out_valid=1; out_data = acc for OR/AND/XOR, ~acc for NOR/NAND/XNOR.
REQ-018 out_valid SHALL rise the cycle after the final beat is accepted (latency 1 from last handshake).
REQ-019 out_data and out_illegal SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 DONE with out_ready=1 SHALL return to IDLE next cycle; no same-cycle operand acceptance (no bypass).
REQ-021 mode changes after the first beat SHALL be ignored until the next operation.
REQ-022 Reserved codes, and codes 4/5 when XOR support is compiled out, SHALL behave as NOR with out_illegal=1.
REQ-023 cnt SHALL be $clog2(NUM_OPERANDS+1) bits and never wrap within an operation.

Reset
REQ-024 rst high SHALL immediately force state IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_illegal=0, in_ready=0.
REQ-025 After rst deasserts, in_ready SHALL be 1; reset mid-ACCUM or mid-DONE SHALL discard the partial/pending result.

Configuration
REQ-026 Macro GATE_ACCUMULATOR_XOR_EN defined: modes 4/5 implement XNOR/XOR parity fold.
REQ-027 Macro undefined: XOR datapath absent; modes 4/5 handled per REQ-022.

Structure
REQ-028 Shared package gate_pkg SHALL hold the mode enum typedef (values per REQ-005) and the FSM state typedef.
REQ-029 SHALL instantiate one combinational sub-module gate_bitwise (mode, a, b -> WIDTH-bit OR/AND/XOR result).

Verification (WIDTH=8, NUM_OPERANDS=4 unless stated)
REQ-030 NOR, beats 0x00,0x00,0x00,0x01 -> out_data 0xFE, out_valid high one cycle after 4th beat.
REQ-031 WIDTH=1, NUM_OPERANDS=2, NOR, pairs (0,0),(1,0),(0,1),(1,1) -> 1,0,0,0.
REQ-032 out_ready low 5 cycles in DONE -> out_valid/out_data stable, in_ready 0, offered beats not consumed.
REQ-033 NAND on beat 1, mode switched to OR on beat 2, beats 0xFF,0xF0,0xFF,0xFF -> 0x0F (NAND kept).
REQ-034 rst pulsed after 2 beats -> out_valid 0; next 4 beats yield fresh result unaffected by discarded beats.
REQ-035 mode 5, beats 0x0F,0x0F,0x00,0x00 -> 0x00, out_illegal 0 with macro; 0xF0, out_illegal 1 without.

Source files
------------

// File: rtl/gate_accumulator_pkg.sv
// Shared types for the gate accumulator: operator modes, FSM states and the
// decoded form of a latched mode.
// Optional feature macro: GATE_ACCUMULATOR_XOR_EN (XNOR/XOR parity fold).
package gate_pkg;

  typedef enum logic [2:0] {
    MODE_NOR   = 3'd0,
    MODE_OR    = 3'd1,
    MODE_NAND  = 3'd2,
    MODE_AND   = 3'd3,
    MODE_XNOR  = 3'd4,
    MODE_XOR   = 3'd5,
    MODE_RSVD6 = 3'd6,
    MODE_RSVD7 = 3'd7
  } gate_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Base operator applied while folding operands.
  typedef enum logic [1:0] {
    OP_OR  = 2'd0,
    OP_AND = 2'd1,
    OP_XOR = 2'd2
  } gate_op_t;

  typedef struct packed {
    gate_op_t op;
    logic     invert;
    logic     illegal;
  } mode_dec_t;

  // Split a mode into base operator plus final inversion. Anything that is
  // not a supported mode in this build folds as NOR and is flagged illegal.
  function automatic mode_dec_t decode_mode(input gate_mode_t mode);
    mode_dec_t d;
    d = '{op: OP_OR, invert: 1'b1, illegal: 1'b1};
    case (mode)
      MODE_NOR:  d = '{op: OP_OR,  invert: 1'b1, illegal: 1'b0};
      MODE_OR:   d = '{op: OP_OR,  invert: 1'b0, illegal: 1'b0};
      MODE_NAND: d = '{op: OP_AND, invert: 1'b1, illegal: 1'b0};
      MODE_AND:  d = '{op: OP_AND, invert: 1'b0, illegal: 1'b0};
`ifdef GATE_ACCUMULATOR_XOR_EN
      MODE_XNOR: d = '{op: OP_XOR, invert: 1'b1, illegal: 1'b0};
      MODE_XOR:  d = '{op: OP_XOR, invert: 1'b0, illegal: 1'b0};
`endif
      default:   d = '{op: OP_OR,  invert: 1'b1, illegal: 1'b1};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/gate_accumulator_if.sv
// Operand/result handshake bundle of the gate accumulator.
// The master side offers operands and consumes results; the slave is the
// accumulator itself.
interface gate_accumulator_if #(
  parameter int WIDTH = 8
);
  logic [2:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_illegal;

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_illegal
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_illegal
  );
endinterface

// File: rtl/gate_accumulator_bitwise.sv
// Combinational bitwise combiner used by the accumulator fold step.
// The XOR path exists only when GATE_ACCUMULATOR_XOR_EN is defined.
module gate_bitwise
  import gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  gate_op_t         mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Apply the selected base operator bit by bit
  always_comb begin
    y = a | b;
    case (mode)
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
`ifdef GATE_ACCUMULATOR_XOR_EN
      OP_XOR:  y = a ^ b;
`endif
      default: y = a | b;
    endcase
  end

endmodule

// File: rtl/gate_accumulator.sv
// Gate accumulator: folds NUM_OPERANDS operand beats with a bitwise gate
// selected by the mode present on the first beat, then presents the result
// until it is consumed.
// Optional feature macro: GATE_ACCUMULATOR_XOR_EN (modes 4/5 as XNOR/XOR);
// without it those modes fold as NOR and raise out_illegal.
module gate_accumulator
  import gate_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int NUM_OPERANDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  gate_accumulator_if.slave  bus
);

  localparam int CNT_W = $clog2(NUM_OPERANDS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_OPERANDS);
  localparam mode_dec_t DEC_RESET = '{op: OP_OR, invert: 1'b1, illegal: 1'b0};

  state_t           state_r, state_s;
  logic [WIDTH-1:0] acc_r, acc_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  mode_dec_t        dec_r, dec_s;
  logic [WIDTH-1:0] out_data_r, out_data_s;
  logic             out_illegal_r, out_illegal_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             accept_s;
  logic [WIDTH-1:0] fold_s;

  gate_bitwise #(.WIDTH(WIDTH)) u_bitwise (
    .mode (dec_r.op),
    .a    (acc_r),
    .b    (bus.in_data),
    .y    (fold_s)
  );

  // in_ready is registered, so it is low during reset and in DONE; this also
  // rules out accepting an operand in the cycle DONE hands back to IDLE.
  assign accept_s = bus.in_valid && in_ready_r;

  // Next state, fold datapath and result capture
  always_comb begin
    state_s       = state_r;
    acc_s         = acc_r;
    cnt_s         = cnt_r;
    dec_s         = dec_r;
    out_data_s    = out_data_r;
    out_illegal_s = out_illegal_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          acc_s   = bus.in_data;
          cnt_s   = CNT_ONE;
          dec_s   = decode_mode(gate_mode_t'(bus.mode));
          state_s = ST_ACCUM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (accept_s) begin
          acc_s = fold_s;
          cnt_s = cnt_r + CNT_ONE;
          if (cnt_s == CNT_LAST) begin
            state_s       = ST_DONE;
            out_data_s    = dec_r.invert ? ~fold_s : fold_s;
            out_illegal_s = dec_r.illegal;
          end else begin
            state_s = ST_ACCUM;
          end
        end else begin
          state_s = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Accumulator, counter, latched mode and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r         <= '0;
      cnt_r         <= '0;
      dec_r         <= DEC_RESET;
      out_data_r    <= '0;
      out_illegal_r <= 1'b0;
      in_ready_r    <= 1'b0;
      out_valid_r   <= 1'b0;
    end else begin
      acc_r         <= acc_s;
      cnt_r         <= cnt_s;
      dec_r         <= dec_s;
      out_data_r    <= out_data_s;
      out_illegal_r <= out_illegal_s;
      in_ready_r    <= (state_s != ST_DONE);
      out_valid_r   <= (state_s == ST_DONE);
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_data    = out_data_r;
  assign bus.out_illegal = out_illegal_r;

endmodule

// File: tb/tb_gate_accumulator.sv
// Self-checking bench for gate_accumulator: a queue-based reference model
// compared every cycle, directed scenarios with literal results, and a
// randomized run with occasional resets.
module tb_gate_accumulator;

  localparam int W = 8;
  localparam int N = 4;

`ifdef GATE_ACCUMULATOR_XOR_EN
  localparam bit XOR_EN = 1'b1;
`else
  localparam bit XOR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  gate_accumulator_if #(.WIDTH(W)) bus ();
  gate_accumulator #(.WIDTH(W), .NUM_OPERANDS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  gate_accumulator_if #(.WIDTH(1)) bus1 ();
  gate_accumulator #(.WIDTH(1), .NUM_OPERANDS(2)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [W-1:0] beats[$];
  logic [2:0]   m_mode;
  bit           m_pending;
  bit           m_ready;
  logic [W-1:0] m_data;
  bit           m_illegal;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result of folding all collected beats under mode md
  task automatic model_result(input logic [2:0] md, output logic [W-1:0] r, output bit ill);
    int kind;
    bit inv;
    kind = 0; inv = 1'b1; ill = 1'b0;
    case (md)
      3'd0: begin kind = 0; inv = 1'b1; end
      3'd1: begin kind = 0; inv = 1'b0; end
      3'd2: begin kind = 1; inv = 1'b1; end
      3'd3: begin kind = 1; inv = 1'b0; end
      3'd4: begin kind = 2; inv = 1'b1; end
      3'd5: begin kind = 2; inv = 1'b0; end
      default: begin kind = 0; inv = 1'b1; ill = 1'b1; end
    endcase
    if ((md == 3'd4 || md == 3'd5) && !XOR_EN) begin
      kind = 0; inv = 1'b1; ill = 1'b1;
    end
    r = (kind == 1) ? {W{1'b1}} : {W{1'b0}};
    foreach (beats[i]) begin
      if (kind == 0)      r = r | beats[i];
      else if (kind == 1) r = r & beats[i];
      else                r = r ^ beats[i];
    end
    if (inv) r = ~r;
  endtask

  // Advance the model by one rising edge using the inputs offered this cycle
  task automatic model_update();
    if (rst) begin
      beats.delete();
      m_pending = 1'b0;
      m_ready   = 1'b0;
      m_data    = '0;
      m_illegal = 1'b0;
    end else if (m_pending) begin
      if (bus.out_ready) begin
        m_pending = 1'b0;
        m_ready   = 1'b1;
      end
    end else begin
      if (bus.in_valid && m_ready) begin
        if (beats.size() == 0) m_mode = bus.mode;
        beats.push_back(bus.in_data);
        if (beats.size() == N) begin
          model_result(m_mode, m_data, m_illegal);
          m_pending = 1'b1;
          beats.delete();
        end
      end
      m_ready = !m_pending;
    end
  endtask

  task automatic compare();
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_ready});
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_pending});
    if (m_pending) begin
      chk("out_data", {24'd0, bus.out_data}, {24'd0, m_data});
      chk("out_illegal", {31'd0, bus.out_illegal}, {31'd0, m_illegal});
    end
  endtask

  // One clock: model steps on the rising edge, outputs compared on the falling edge
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic send4(input logic [2:0] m0, input logic [2:0] mr,
                       input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [W-1:0] d2, input logic [W-1:0] d3);
    logic [W-1:0] d [4];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.mode     = (i == 0) ? m0 : mr;
      bus.in_data  = d[i];
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("rst in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst out_data", {24'd0, bus.out_data}, 32'd0);
    chk("rst out_illegal", {31'd0, bus.out_illegal}, 32'd0);
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic pair1(input logic a, input logic b, input logic exp);
    bus1.mode     = 3'd0;
    bus1.in_valid = 1'b1;
    bus1.in_data  = a;
    step();
    bus1.in_data  = b;
    step();
    bus1.in_valid = 1'b0;
    chk("w1 out_valid", {31'd0, bus1.out_valid}, 32'd1);
    chk("w1 nor", {31'd0, bus1.out_data}, {31'd0, exp});
    bus1.out_ready = 1'b1;
    step();
    bus1.out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.mode = 3'd0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    bus1.mode = 3'd0; bus1.in_valid = 1'b0; bus1.in_data = 1'b0; bus1.out_ready = 1'b0;
    m_mode = 3'd0; m_pending = 1'b0; m_ready = 1'b0; m_data = '0; m_illegal = 1'b0;

    @(negedge clk);
    pulse_reset();
    chk("ready after rst", {31'd0, bus.in_ready}, 32'd1);

    // NOR of 00,00,00,01 -> FE, valid one cycle after the last beat
    send4(3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h01);
    chk("nor valid", {31'd0, bus.out_valid}, 32'd1);
    chk("nor data", {24'd0, bus.out_data}, 32'hFE);
    release_result();
    chk("nor released", {31'd0, bus.out_valid}, 32'd0);

    // Held result under back-pressure, offered beats must not be taken
    send4(3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h01);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hAA;
      step();
      chk("hold valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold data", {24'd0, bus.out_data}, 32'hFE);
      chk("hold in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
    release_result();
    send4(3'd1, 3'd1, 8'h01, 8'h02, 8'h04, 8'h08);
    chk("or after hold", {24'd0, bus.out_data}, 32'h0F);
    release_result();

    // Mode latched on the first beat: NAND survives a switch to OR
    send4(3'd2, 3'd1, 8'hFF, 8'hF0, 8'hFF, 8'hFF);
    chk("nand kept", {24'd0, bus.out_data}, 32'h0F);
    chk("nand legal", {31'd0, bus.out_illegal}, 32'd0);
    release_result();

    // Reset mid-operation discards the partial fold
    bus.in_valid = 1'b1; bus.mode = 3'd1; bus.in_data = 8'hFF;
    step(); step();
    bus.in_valid = 1'b0;
    pulse_reset();
    chk("rst discard valid", {31'd0, bus.out_valid}, 32'd0);
    send4(3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h01);
    chk("fresh after rst", {24'd0, bus.out_data}, 32'hFE);
    release_result();

    // Mode 5 depends on whether the XOR fold is built in
    send4(3'd5, 3'd5, 8'h0F, 8'h0F, 8'h00, 8'h00);
    chk("mode5 data", {24'd0, bus.out_data}, XOR_EN ? 32'h00 : 32'hF0);
    chk("mode5 illegal", {31'd0, bus.out_illegal}, XOR_EN ? 32'd0 : 32'd1);
    release_result();

    // Reserved mode folds as NOR and is flagged
    send4(3'd7, 3'd3, 8'h10, 8'h01, 8'h00, 8'h00);
    chk("rsvd data", {24'd0, bus.out_data}, 32'hEE);
    chk("rsvd illegal", {31'd0, bus.out_illegal}, 32'd1);
    release_result();

    // Single-bit, two-operand NOR truth table
    pair1(1'b0, 1'b0, 1'b1);
    pair1(1'b1, 1'b0, 1'b0);
    pair1(1'b0, 1'b1, 1'b0);
    pair1(1'b1, 1'b1, 1'b0);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 249) == 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = W'($urandom);
      bus.mode      = 3'($urandom_range(0, 7));
      bus.out_ready = ($urandom_range(0, 2) == 0);
      step();
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
